// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher stream datapath: FSM states,
// header field positions and the A/B select polarity used by mux and stream_demux.
package cipher_pkg;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } demux_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Header layout for an N-bit word: destination at bit N-1, LEN in [N-2:0].
    function automatic int unsigned hdr_dest_pos(input int unsigned n);
        return n - 1;
    endfunction

    function automatic int unsigned hdr_len_msb(input int unsigned n);
        return n - 2;
    endfunction

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready output register; a load in the same cycle as a drain
// keeps valid high with the new word.
module stream_reg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] data,
    output logic         valid,
    input  logic         ready
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Framed 1-to-2 stream demultiplexer: a header word picks destination A or B
// and a payload length; payload words are steered into registered outputs.
module stream_demux
    import cipher_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_a,
    output logic         out_a_valid,
    input  logic         out_a_ready,
    output logic [N-1:0] out_b,
    output logic         out_b_valid,
    input  logic         out_b_ready,
    output logic         busy,
    output logic         sel_q
);

    demux_state_t state, state_next;
    logic [N-2:0] count;
    logic         sel_valid;
    logic         sel_ready;
    logic         accept;
    logic         load_a;
    logic         load_b;

    assign sel_valid = (sel_q == SEL_A) ? out_a_valid : out_b_valid;
    assign sel_ready = (sel_q == SEL_A) ? out_a_ready : out_b_ready;
    assign accept    = in_valid && in_ready;
    assign load_a    = accept && (state == PAYLOAD) && (sel_q == SEL_A);
    assign load_b    = accept && (state == PAYLOAD) && (sel_q == SEL_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            count <= '0;
            sel_q <= SEL_B;
        end else begin
            state <= state_next;
            if (accept) begin
                if (state == HDR) begin
                    sel_q <= in_data[hdr_dest_pos(N)];
                    count <= in_data[hdr_len_msb(N):0];
                end else if (count != '0) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR:     if (accept) state_next = PAYLOAD;
            PAYLOAD: if (accept && count == '0) state_next = HDR;
            default: state_next = HDR;
        endcase
    end

    // in_ready depends only on state, sel_q and the selected output's handshake.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state == PAYLOAD);
        if (!rst) begin
            case (state)
                HDR:     in_ready = 1'b1;
                PAYLOAD: in_ready = !sel_valid || sel_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    stream_reg #(.N(N)) u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load_a),
        .din   (in_data),
        .data  (out_a),
        .valid (out_a_valid),
        .ready (out_a_ready)
    );

    stream_reg #(.N(N)) u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load_b),
        .din   (in_data),
        .data  (out_b),
        .valid (out_b_valid),
        .ready (out_b_ready)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed frame scenarios plus randomized traffic,
// compared every cycle against a frame-level reference model.
module tb_stream_demux;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_a;
    logic         out_a_valid;
    logic         out_a_ready;
    logic [N-1:0] out_b;
    logic         out_b_valid;
    logic         out_b_ready;
    logic         busy;
    logic         sel_q;

    int checks = 0;
    int errors = 0;

    stream_demux #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a       (out_a),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b       (out_b),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .busy        (busy),
        .sel_q       (sel_q)
    );

    always #5 clk = ~clk;

    // Reference model: frame progress as "words still owed", plus the word
    // each destination is currently presenting.
    bit         m_in_frame = 0;
    bit         m_dest     = 0;
    int         m_left     = 0;
    bit         m_av = 0, m_bv = 0;
    logic [7:0] m_ad = '0, m_bd = '0;
    logic       obs_rdy, exp_rdy;

    function automatic logic model_rdy();
        if (rst) return 1'b0;
        if (!m_in_frame) return 1'b1;
        if (m_dest) return !(m_av && !out_a_ready);
        return !(m_bv && !out_b_ready);
    endfunction

    task automatic model_edge();
        bit acc;
        bit load_a, load_b;
        if (rst) begin
            m_in_frame = 0; m_dest = 0; m_left = 0;
            m_av = 0; m_bv = 0; m_ad = '0; m_bd = '0;
            return;
        end
        acc = in_valid && exp_rdy;
        load_a = 0; load_b = 0;
        if (acc && !m_in_frame) begin
            m_dest     = in_data[N-1];
            m_left     = int'(in_data[N-2:0]) + 1;
            m_in_frame = 1;
        end else if (acc) begin
            if (m_dest) begin load_a = 1; m_ad = in_data; m_av = 1; end
            else        begin load_b = 1; m_bd = in_data; m_bv = 1; end
            m_left--;
            if (m_left == 0) m_in_frame = 0;
        end
        if (!load_a && m_av && out_a_ready) m_av = 0;
        if (!load_b && m_bv && out_b_ready) m_bv = 0;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ra,
                         input logic rb, input logic r);
        in_valid = v; in_data = d; out_a_ready = ra; out_b_ready = rb; rst = r;
        @(negedge clk);
        obs_rdy = in_ready;
        exp_rdy = model_rdy();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [20:0] obs_vec();
        return {obs_rdy, busy, sel_q, out_a_valid, out_a, out_b_valid, out_b};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {exp_rdy, logic'(m_in_frame), logic'(m_dest), logic'(m_av), m_ad,
                logic'(m_bv), m_bd};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
            checks++;
            if (obs_rdy !== 1'b0 || out_a_valid !== 1'b0 || out_b_valid !== 1'b0 ||
                out_a !== 8'h00 || out_b !== 8'h00 || busy !== 1'b0 || sel_q !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs_vec(), 21'h0);
            end
        end
    endtask

    task automatic test_single_a();
        logic [7:0] seq [3] = '{8'h80, 8'h5A, 8'h00};
        logic       vld [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(vld[i], seq[i], 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_a step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (out_a_valid !== 1'b0 || out_a !== 8'h5A || busy !== 1'b0 || out_b_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_a_end: got a_v=%b a=%h busy=%b b_v=%b want 0 5a 0 0",
                     out_a_valid, out_a, busy, out_b_valid);
        end
    endtask

    task automatic test_frame_b();
        logic [7:0] seq [5] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL frame_b step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i > 0) begin
                checks++;
                if (out_b !== seq[i] || out_b_valid !== 1'b1 || busy !== (i < 4)) begin
                    errors++;
                    $display("FAIL frame_b word %0d: got b=%h v=%b busy=%b want %h 1 %b",
                             i, out_b, out_b_valid, busy, seq[i], i < 4);
                end
            end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] d  [6] = '{8'h81, 8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC2};
        logic       ra [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, d[i], ra[i], 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i >= 2 && i <= 4) begin
                checks++;
                if (obs_rdy !== 1'b0 || out_a !== 8'hC1 || out_a_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL backpressure_hold %0d: got rdy=%b a=%h want 0 c1", i, obs_rdy, out_a);
                end
            end
        end
        checks++;
        if (out_a !== 8'hC2 || out_a_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_last: got a=%h v=%b busy=%b want c2 1 0", out_a, out_a_valid, busy);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_interleave();
        logic [7:0] d [4] = '{8'h80, 8'hA5, 8'h00, 8'h77};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i], 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL interleave step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1 || out_a !== 8'hA5 || out_b !== 8'h77) begin
            errors++;
            $display("FAIL interleave_both: got a=%b/%h b=%b/%h want 1/a5 1/77",
                     out_a_valid, out_a, out_b_valid, out_b);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_boundary();
        int bad = 0;
        drive(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
            if (obs_vec() !== exp_vec() || out_b !== 8'(i) || busy !== (i < 127)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL boundary_128: got %0d bad cycles want 0", bad);
        end
        drive(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, 8'hE0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'hE0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_a !== 8'h3C || out_a_valid !== 1'b1 || out_b_valid !== 1'b0 ||
            sel_q !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL boundary_reset: got a=%h/%b b_v=%b sel=%b busy=%b want 3c/1 0 1 0",
                     out_a, out_a_valid, out_b_valid, sel_q, busy);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 299) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_frame_b();
        test_backpressure();
        test_interleave();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Framed, registered 1-to-2 stream demultiplexer: the inverse of the cipher datapath's 2-to-1 `mux`. It accepts a single valid/ready word stream from the input pins and steers each frame to destination A (e.g. the key-load path) or destination B (e.g. the data/XOR path). Each frame is a header word followed by a payload. Both outputs are registered valid/ready streams with full throughput.

## Interface
- `N`, default 8: word width; N ≥ 2.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input N: header or payload word.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: word accepted when `in_valid && in_ready`.
- `out_a` output N: destination A word.
- `out_a_valid` output 1: `out_a` valid.
- `out_a_ready` input 1: A consumer ready.
- `out_b` output N: destination B word.
- `out_b_valid` output 1: `out_b` valid.
- `out_b_ready` input 1: B consumer ready.
- `busy` output 1: frame in progress (state PAYLOAD).
- `sel_q` output 1: latched destination of the current or last frame; 1 = A, 0 = B. Polarity matches `mux`.

## Operation
- Header word layout:
  - `in_data[N-1]` is the destination: 1 routes to A, 0 routes to B.
  - `in_data[N-2:0]` is LEN. The payload is LEN+1 words, so 1..2^(N-1) words (N=8: 1..128).
- FSM has two states.
  - HDR: `in_ready`=1 (outside reset). On accept: `sel_q` ← bit N-1; remaining-count register (N-1 bits) ← LEN; go to PAYLOAD.
  - PAYLOAD: `in_ready` = !sel_valid || sel_ready, where sel_* is the output picked by `sel_q`.
    - On accept: the word loads into the selected output register, and that output's valid is set.
    - If count==0, return to HDR. Otherwise count decrements.
- The header is never forwarded to either output.
- Each output register is an independent one-entry register:
  - Valid is set on load.
  - Valid clears on `valid && ready` with no simultaneous load.
  - Load and drain in the same cycle keeps valid=1 with the new word.
- The unselected output is never written. It keeps draining any pending word, so A and B may both be valid at once.
- The unselected output's ready does not affect `in_ready`.
- Count arithmetic is modulo 2^(N-1), but count never underflows because the exit is taken at 0.

## Timing
- Reset values:
  - State = HDR.
  - `busy`=0, `sel_q`=0.
  - `out_a`=`out_b`=0, `out_a_valid`=`out_b_valid`=0.
  - `in_ready`=0 while `rst` is high.
- Latency: a payload word accepted at edge k appears on its output at edge k (valid from cycle k+1). One cycle of register latency.
- Throughput: one word per cycle in PAYLOAD while the selected consumer holds ready=1.
- The header costs one input cycle.
- After the last payload word, a header may be accepted on the very next cycle, even if the last word is still pending on the output.
- Back-to-back frames to alternate destinations need no bubble beyond the header.
- Backpressure: if the selected output is valid and its ready=0, `in_ready`=0. Nothing is dropped or overwritten.
- `in_ready` is combinational from state, `sel_q`, selected valid and selected ready. There is no path from `in_valid` or `in_data` to `in_ready`.
- Reset mid-frame discards the remaining frame state and both pending output words. The next accepted word after reset is treated as a header.
- `in_valid` without a handshake (`in_ready`=0) has no effect. `in_data` may change freely while not accepted.

## Structure
- Shared package `cipher_pkg`:
  - State enumeration (HDR, PAYLOAD).
  - Localparam helpers for the header field positions: destination bit N-1 and LEN field [N-2:0].
  - Constants `SEL_A`=1'b1 and `SEL_B`=1'b0, shared with `mux` users.
- Sub-module `stream_reg #(N)`: the one-entry valid/ready output register, instantiated twice (A and B).
- The top level holds the FSM, the count and `sel_q`, and the load-enable steering.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `in_valid`=1. Expect `in_ready`=0, both valids=0, both outputs 0x00, `busy`=0.
- **Single word to A:** header 0x80 then payload 0x5A, both readies=1. Expect `out_a`=0x5A valid for exactly one cycle, `out_b_valid` never asserted, FSM back in HDR.
- **Frame to B:** header 0x03 then 0x11, 0x22, 0x33, 0x44 back-to-back. Expect `out_b` to show 0x11..0x44 on 4 consecutive cycles and `busy` to deassert after the 4th accept.
- **Backpressure:** header 0x81 (A, 2 words). Drop `out_a_ready` to 0 for 3 cycles after the first word. Expect `in_ready`=0, the second word held, no loss, order preserved.
- **Interleaved destinations:** A frame of 1 word with `out_a_ready`=0, then header 0x00 plus word 0x77 to B. Expect both valids high together, 0x77 delivered on B while A still holds its word.
- **Boundary:** header 0x7F (B, 128 words) completes correctly. Reset mid-frame at word 50; the next word 0x80 is taken as a header to A.
